// File: rtl/vga_lowres_fb.sv
// Low-resolution, double-buffered framebuffer scanned out on 640x480@60 VGA.
// Each 2^CELL_LOG2 square pixel cell takes its {r,g,b} colour from one VRAM word.
module vga_lowres_fb #(
  parameter  int BPP       = 2,
  parameter  int CELL_LOG2 = 4,
  localparam int COLS      = 640 >> CELL_LOG2,
  localparam int CELLS     = COLS * (480 >> CELL_LOG2),
  localparam int DEPTH     = 2 * CELLS,
  localparam int AW        = $clog2(DEPTH),
  localparam int DW        = 3 * BPP
) (
  input  logic          clk,
  input  logic          reset,
  output logic [BPP-1:0] red,
  output logic [BPP-1:0] grn,
  output logic [BPP-1:0] blu,
  output logic          hs,
  output logic          vs,
  output logic          fr,
  output logic          active,
  input  logic          page_sel,
  output logic          page_cur,
  input  logic [AW-1:0] vram_waddr,
  input  logic [DW-1:0] vram_wdata,
  input  logic          vram_we
);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] H_ACT    = 10'd640;
  localparam logic [9:0] V_ACT    = 10'd480;
  localparam logic [9:0] HS_FIRST = 10'd656;
  localparam logic [9:0] HS_LAST  = 10'd751;
  localparam logic [9:0] VS_FIRST = 10'd490;
  localparam logic [9:0] VS_LAST  = 10'd491;

  logic [9:0]    hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;
  logic [AW-1:0] rowbase_q, rowbase_d;
  logic          page_cur_q, page_cur_d;

  logic          hs0, vs0, act0, fr0;
  logic [9:0]    col0;
  logic [AW-1:0] raddr_d;

  logic [AW-1:0] raddr_p1;
  logic          vld_p1, hs_p1, vs_p1, act_p1, fr_p1;

  logic [DW-1:0] rdata_p2;
  logic          vld_p2, hs_p2, vs_p2, act_p2, fr_p2;
  logic [DW-1:0] pix_p2;

  logic [DW-1:0] mem [DEPTH];

  // Stage 0: raster counters, row base accumulator and frame-aligned page flip
  always_comb begin
    hc_d       = hc_q + 10'd1;
    vc_d       = vc_q;
    rowbase_d  = rowbase_q;
    page_cur_d = page_cur_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d       = '0;
        rowbase_d  = '0;
        page_cur_d = page_sel;
      end else begin
        vc_d = vc_q + 10'd1;
        // Advance only into another visible cell row so the base never runs past the page.
        if ((vc_q < V_ACT - 10'd1) && (&vc_q[CELL_LOG2-1:0]))
          rowbase_d = rowbase_q + AW'(COLS);
      end
    end
  end

  always_comb begin
    hs0  = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
    vs0  = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
    act0 = (hc_q < H_ACT) && (vc_q < V_ACT);
    fr0  = (hc_q == '0) && (vc_q == '0);
    col0 = hc_q >> CELL_LOG2;
    // Blanking reads are parked on address 0 so the RAM is never indexed past DEPTH.
    raddr_d = '0;
    if (act0)
      raddr_d = (page_cur_q ? AW'(CELLS) : '0) + rowbase_q + AW'(col0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q       <= '0;
      vc_q       <= '0;
      rowbase_q  <= '0;
      page_cur_q <= 1'b0;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      rowbase_q  <= rowbase_d;
      page_cur_q <= page_cur_d;
    end
  end

  // Stage 1: registered read address, timing flags delayed alongside
  always_ff @(posedge clk) begin
    raddr_p1 <= raddr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      act_p1 <= 1'b0;
      fr_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b1;
      hs_p1  <= hs0;
      vs_p1  <= vs0;
      act_p1 <= act0;
      fr_p1  <= fr0;
    end
  end

  // Stage 2: VRAM read data registered; write port shares the clock (read-first)
  always_ff @(posedge clk) begin
    if (vram_we && (32'(vram_waddr) < DEPTH))
      mem[vram_waddr] <= vram_wdata;
  end

  always_ff @(posedge clk) begin
    rdata_p2 <= mem[raddr_p1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      act_p2 <= 1'b0;
      fr_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      act_p2 <= act_p1;
      fr_p2  <= fr_p1;
    end
  end

  assign pix_p2   = (vld_p2 && act_p2) ? rdata_p2 : '0;
  assign red      = pix_p2[DW-1 -: BPP];
  assign grn      = pix_p2[2*BPP-1 -: BPP];
  assign blu      = pix_p2[BPP-1:0];
  assign hs       = hs_p2;
  assign vs       = vs_p2;
  assign fr       = fr_p2 && vld_p2;
  assign active   = act_p2 && vld_p2;
  assign page_cur = page_cur_q;

endmodule

// File: tb/tb_vga_lowres_fb.sv
// Directed bench for vga_lowres_fb: one 16-pixel-cell instance and one 8-pixel-cell instance.
// Long blanking stretches are skipped by loading the raster counters directly.
module tb_vga_lowres_fb;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        reset;
  logic [1:0]  red4, grn4, blu4, red3, grn3, blu3;
  logic        hs4, vs4, fr4, act4, psel4, pcur4;
  logic        hs3, vs3, fr3, act3, psel3, pcur3;
  logic [11:0] wa4;
  logic [13:0] wa3;
  logic [5:0]  wd4, wd3;
  logic        we4, we3;

  vga_lowres_fb #(.BPP(2), .CELL_LOG2(4)) dut (
    .clk(clk), .reset(reset), .red(red4), .grn(grn4), .blu(blu4),
    .hs(hs4), .vs(vs4), .fr(fr4), .active(act4),
    .page_sel(psel4), .page_cur(pcur4),
    .vram_waddr(wa4), .vram_wdata(wd4), .vram_we(we4));

  vga_lowres_fb #(.BPP(2), .CELL_LOG2(3)) dut3 (
    .clk(clk), .reset(reset), .red(red3), .grn(grn3), .blu(blu3),
    .hs(hs3), .vs(vs3), .fr(fr3), .active(act3),
    .page_sel(psel3), .page_cur(pcur3),
    .vram_waddr(wa3), .vram_wdata(wd3), .vram_we(we3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr4(input logic [11:0] a, input logic [5:0] d);
    wa4 = a; wd4 = d; we4 = 1'b1;
    @(negedge clk);
    we4 = 1'b0;
  endtask

  task automatic wr3(input logic [13:0] a, input logic [5:0] d);
    wa3 = a; wd3 = d; we3 = 1'b1;
    @(negedge clk);
    we3 = 1'b0;
  endtask

  initial begin
    #3800000;
    $display("FAIL watchdog: cycle budget exhausted, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_hs, e_vs, e_act, e_fr, e_rgb, hs_low0, fr_cnt, fall0, fall1;
    int pos, x, y, cx, cy, n;
    logic prev_hs, known, seen, prev_act, h1, h2, h3;
    logic [5:0] exp_rgb, rgb, prev_rgb;

    reset = 1'b1; we4 = 1'b0; we3 = 1'b0; wa4 = '0; wa3 = '0; wd4 = '0; wd3 = '0;
    psel4 = 1'b0; psel3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rgb", {red4, grn4, blu4}, 6'h00);
    chk("rst_hs", hs4, 1'b1);
    chk("rst_vs", vs4, 1'b1);
    chk("rst_fr", fr4, 1'b0);
    chk("rst_active", act4, 1'b0);
    chk("rst_page", pcur4, 1'b0);

    wr4(12'd0, 6'h3F); wr4(12'd1, 6'h00); wr4(12'd40, 6'h00);
    wr4(12'd41, 6'h30); wr4(12'd1200, 6'h03);
    wr3(14'd0, 6'h15); wr3(14'd4799, 6'h0C); wr3(14'd9600, 6'h2A);
    reset = 1'b0;

    // Stream the first 34 lines against a raster model
    e_hs = 0; e_vs = 0; e_act = 0; e_fr = 0; e_rgb = 0; hs_low0 = 0; fr_cnt = 0;
    fall0 = -1; fall1 = -1; prev_hs = 1'b1;
    for (int k = 0; k <= 34 * 800; k++) begin
      @(negedge clk);
      rgb = {red4, grn4, blu4};
      if (k == 0) chk("fr_after_1clk", fr4, 1'b0);
      if (k == 1) begin
        chk("fr_after_2clk", fr4, 1'b1);
        chk("px_0_0", rgb, 6'h3F);
        chk("l3_px_0_0_noalias", {red3, grn3, blu3}, 6'h15);
      end
      if (k == 1606) chk("collide_old", rgb, 6'h3F);
      if (k == 1607) chk("collide_new", rgb, 6'h2A);
      if (k == 3 * 800 + 1) chk("px_0_3_new", rgb, 6'h2A);
      if (k == 16 * 800 + 17) chk("px_16_16", rgb, 6'h30);
      if (k == 31 * 800 + 32) chk("px_31_31", rgb, 6'h30);
      if (k == 16 * 800 + 33) chk("px_32_16_blankcell", {1'b0, act4}, 2'b01);
      if (k >= 1) begin
        pos = k - 1; x = pos % 800; y = pos / 800;
        if (hs4 !== !(x >= 656 && x <= 751)) e_hs++;
        if (vs4 !== !(y >= 490 && y <= 491)) e_vs++;
        if (act4 !== (x < 640 && y < 480)) e_act++;
        if (fr4 !== (x == 0 && y == 0)) e_fr++;
        if (fr4) fr_cnt++;
        if (y == 0 && !hs4) hs_low0++;
        if (prev_hs && !hs4) begin
          if (fall0 < 0) fall0 = k; else if (fall1 < 0) fall1 = k;
        end
        prev_hs = hs4;
        known = 1'b1; exp_rgb = 6'h00;
        cx = x >> 4; cy = y >> 4;
        if (x < 640 && y < 480) begin
          if (cx == 0 && cy == 0) exp_rgb = (y < 2 || (y == 2 && x <= 5)) ? 6'h3F : 6'h2A;
          else if ((cx == 1 && cy == 0) || (cx == 0 && cy == 1)) exp_rgb = 6'h00;
          else if (cx == 1 && cy == 1) exp_rgb = 6'h30;
          else known = 1'b0;
        end
        if (known && rgb !== exp_rgb) e_rgb++;
      end
      // Write cell 0 in the same cycle its pixel (5,2) is read
      if (k == 1605) begin wa4 = 12'd0; wd4 = 6'h2A; we4 = 1'b1; end
      if (k == 1606) we4 = 1'b0;
    end
    chk("stream_hs_errs", e_hs, 0);
    chk("stream_vs_errs", e_vs, 0);
    chk("stream_active_errs", e_act, 0);
    chk("stream_fr_errs", e_fr, 0);
    chk("stream_rgb_errs", e_rgb, 0);
    chk("hs_low_line0", hs_low0, 96);
    chk("hs_first_low_x", fall0 - 1, 656);
    chk("hs_period", fall1 - fall0, 800);
    chk("fr_pulses", fr_cnt, 1);

    // Mid-frame page request must not take effect yet
    psel4 = 1'b1;
    repeat (5) @(negedge clk);
    chk("page_hold_midframe", pcur4, 1'b0);

    // 8-pixel cells: jump to line 479, row base 59*80
    force dut3.hc_q = 10'd0; force dut3.vc_q = 10'd479; force dut3.rowbase_q = 14'd4720;
    @(negedge clk);
    release dut3.hc_q; release dut3.vc_q; release dut3.rowbase_q;
    seen = 1'b0; prev_act = 1'b0; prev_rgb = '0; rgb = '0;
    for (int k = 0; k < 810; k++) begin
      @(negedge clk);
      if (!seen && prev_act && !act3) begin
        seen = 1'b1; rgb = prev_rgb;
      end
      prev_act = act3; prev_rgb = {red3, grn3, blu3};
    end
    chk("l3_last_line_end_seen", seen, 1'b1);
    chk("l3_px_639_479", rgb, 6'h0C);

    // Vertical sync width, then the frame boundary with the page flip
    force dut.hc_q = 10'd0; force dut.vc_q = 10'd485; force dut.rowbase_q = 12'd0;
    @(negedge clk);
    release dut.hc_q; release dut.vc_q; release dut.rowbase_q;
    n = 0;
    while (vs4 && n < 8000) begin @(negedge clk); n++; end
    chk("vs_fall_seen", vs4, 1'b0);
    n = 0;
    while (!vs4 && n < 3000) begin @(negedge clk); n++; end
    chk("vs_low_len", n, 1600);
    n = 0; h1 = pcur4; h2 = pcur4; h3 = pcur4;
    while (!fr4 && n < 30000) begin
      h3 = h2; h2 = h1; h1 = pcur4;
      @(negedge clk); n++;
    end
    chk("flip_fr_seen", fr4, 1'b1);
    chk("flip_page_now", pcur4, 1'b1);
    chk("flip_page_3clk_before", h3, 1'b0);
    chk("flip_page_2clk_before", h2, 1'b1);
    chk("flip_px_0_0", {red4, grn4, blu4}, 6'h03);

    // Reset in the middle of a visible line
    force dut.hc_q = 10'd300; force dut.vc_q = 10'd200; force dut.rowbase_q = 12'd480;
    @(negedge clk);
    release dut.hc_q; release dut.vc_q; release dut.rowbase_q;
    repeat (2) @(negedge clk);
    chk("pre_reset_active", act4, 1'b1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_out", {red4, grn4, blu4, hs4, vs4, fr4, act4, pcur4}, {6'h00, 5'b11000});
    end
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_fr_1clk", fr4, 1'b0);
    @(negedge clk);
    chk("midrst_fr_2clk", fr4, 1'b1);
    chk("midrst_active", act4, 1'b1);
    chk("midrst_page", pcur4, 1'b0);
    chk("midrst_px_0_0", {red4, grn4, blu4}, 6'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
